// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the mem_responder slice.
package mem_resp_pkg;

  localparam int unsigned LATENCY_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef enum logic {
    PORT1,
    PORT2
  } port_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port memory: synchronous write, registered read, contents preset to mem[a]=a.
module mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  function automatic logic [DEPTH-1:0][DATA_W-1:0] init_contents();
    logic [DEPTH-1:0][DATA_W-1:0] m;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      m[ADDR_W'(a)] = DATA_W'(a);
    end
    return m;
  endfunction

  // Power-up image only; there is deliberately no reset on the storage.
  logic [DEPTH-1:0][DATA_W-1:0] mem_q = init_contents();

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/mem_responder.sv
// Two-port request/ack memory responder: one transaction at a time, fixed latency,
// fair alternation when both ports request together.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              req2,
  input  logic              we2,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic              ack1,
  output logic              ack2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              read_busy,
  output logic              write_busy
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  port_t               port_q, port_d;
  port_t               last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [DATA_W-1:0]   rdata2_q, rdata2_d;
  port_t               grant;
  logic                tie;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_rdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      port_q   <= PORT1;
      last_q   <= PORT2;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata1_q <= rdata1_d;
      rdata2_q <= rdata2_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata1_d = rdata1_q;
    rdata2_d = rdata2_q;
    ack1     = 1'b0;
    ack2     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = addr_q;
    tie      = req1 && req2;
    grant    = tie ? ((last_q == PORT2) ? PORT1 : PORT2) : (req1 ? PORT1 : PORT2);

    unique case (state_q)
      IDLE: begin
        // Present the winner's address now so the registered read is ready even at LATENCY=1.
        mem_addr = (grant == PORT1) ? addr1 : addr2;
        if (req1 || req2) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
          port_d  = grant;
          we_d    = (grant == PORT1) ? we1 : we2;
          addr_d  = (grant == PORT1) ? addr1 : addr2;
          wdata_d = (grant == PORT1) ? wdata1 : wdata2;
          // Only contested grants advance the alternation; lone requests leave it alone.
          if (tie) begin
            last_d = grant;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          // Load read data on entry to RESP so it is already valid alongside ack.
          if (!we_q) begin
            if (port_q == PORT1) rdata1_d = mem_rdata;
            else                 rdata2_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        mem_we  = we_q;
        ack1    = (port_q == PORT1);
        ack2    = (port_q == PORT2);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata1     = rdata1_q;
  assign rdata2     = rdata2_q;
  assign read_busy  = ((state_q == WAIT) || (state_q == RESP)) && !we_q;
  assign write_busy = ((state_q == WAIT) || (state_q == RESP)) && we_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// against a cycle-count/array reference model.
module tb_mem_responder;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req1, we1, req2, we2;
  logic [7:0] addr1, wdata1, addr2, wdata2;
  logic       ack1, ack2, read_busy, write_busy;
  logic [7:0] rdata1, rdata2;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_m [256];
  logic [7:0] rd_m [0:2];
  int         last_m;

  mem_responder #(
    .LATENCY (L),
    .ADDR_W  (8),
    .DATA_W  (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .req2       (req2),
    .we2        (we2),
    .addr2      (addr2),
    .wdata2     (wdata2),
    .ack1       (ack1),
    .ack2       (ack2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .read_busy  (read_busy),
    .write_busy (write_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack1"}, 32'(ack1), 0);
    chk({tag, "_ack2"}, 32'(ack2), 0);
    chk({tag, "_rbusy"}, 32'(read_busy), 0);
    chk({tag, "_wbusy"}, 32'(write_busy), 0);
    chk({tag, "_rdata1"}, 32'(rdata1), 0);
    chk({tag, "_rdata2"}, 32'(rdata2), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req1 = 1'b0;
    req2 = 1'b0;
    rst  = 1'b1;
    #2;
    chk_idle_outputs("reset");
    rd_m[1] = '0;
    rd_m[2] = '0;
    last_m  = 2;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one or two simultaneous requests and check every cycle until both complete.
  // Sample n=1 is the IDLE cycle before capture; a served transaction is busy for
  // L+1 cycles ending in its ack cycle, and a queued second one starts after one IDLE cycle.
  task automatic run(input bit v1, input bit w1, input logic [7:0] a1, input logic [7:0] d1,
                     input bit v2, input bit w2, input logic [7:0] a2, input logic [7:0] d2);
    int         first, second, t1, t2;
    bit         eack [0:2];
    bit         erb, ewb;
    bit         wv [0:2];
    logic [7:0] av [0:2];
    logic [7:0] dv [0:2];
    wv[0] = 0; av[0] = '0; dv[0] = '0;
    wv[1] = w1; av[1] = a1; dv[1] = d1;
    wv[2] = w2; av[2] = a2; dv[2] = d2;
    first  = v1 ? 1 : 2;
    second = 0;
    if (v1 && v2) begin
      first  = (last_m == 2) ? 1 : 2;
      second = 3 - first;
      last_m = first;
    end
    t1 = L + 2;
    t2 = 2 * L + 4;
    @(posedge clk);
    #1;
    req1 = v1; we1 = w1; addr1 = a1; wdata1 = d1;
    req2 = v2; we2 = w2; addr2 = a2; wdata2 = d2;
    for (int n = 1; n <= 2 * L + 6; n++) begin
      @(negedge clk);
      eack[0] = 0;
      eack[1] = (first == 1 && n == t1) || (second == 1 && n == t2);
      eack[2] = (first == 2 && n == t1) || (second == 2 && n == t2);
      erb = (n >= 2 && n <= t1 && !wv[first]) ||
            (second != 0 && n >= t1 + 2 && n <= t2 && !wv[second]);
      ewb = (n >= 2 && n <= t1 && wv[first]) ||
            (second != 0 && n >= t1 + 2 && n <= t2 && wv[second]);
      for (int p = 1; p <= 2; p++) begin
        if (eack[p]) begin
          if (wv[p]) mem_m[av[p]] = dv[p];
          else       rd_m[p] = mem_m[av[p]];
        end
      end
      chk("ack1", 32'(ack1), 32'(eack[1]));
      chk("ack2", 32'(ack2), 32'(eack[2]));
      chk("read_busy", 32'(read_busy), 32'(erb));
      chk("write_busy", 32'(write_busy), 32'(ewb));
      chk("rdata1", 32'(rdata1), 32'(rd_m[1]));
      chk("rdata2", 32'(rdata2), 32'(rd_m[2]));
      if (eack[1] || eack[2]) begin
        @(posedge clk);
        #1;
        if (eack[1]) req1 = 1'b0;
        if (eack[2]) req2 = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    req2 = 1'b0; we2 = 1'b0; addr2 = '0; wdata2 = '0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'(i);
    rd_m[0] = '0; rd_m[1] = '0; rd_m[2] = '0;
    last_m = 2;

    repeat (2) @(negedge clk);
    chk_idle_outputs("por");
    rst = 1'b0;

    // Basic read of power-up contents.
    run(1, 0, 8'd5, 8'd0, 0, 0, 8'd0, 8'd0);
    chk("read5_rdata1", 32'(rdata1), 5);

    // Write then read back from the other port.
    run(1, 1, 8'd5, 8'd1, 0, 0, 8'd0, 8'd0);
    run(0, 0, 8'd0, 8'd0, 1, 0, 8'd5, 8'd0);
    chk("wr_rd_rdata2", 32'(rdata2), 1);
    chk("wr_rd_rdata1_held", 32'(rdata1), 5);

    // Simultaneous pair after reset: port1 first, then the next tie goes to port2.
    do_reset();
    run(1, 1, 8'd5, 8'd2, 1, 0, 8'd5, 8'd0);
    chk("tie_rdata2", 32'(rdata2), 2);
    run(1, 0, 8'd7, 8'd0, 1, 0, 8'd8, 8'd0);
    chk("tie2_rdata1", 32'(rdata1), 7);
    chk("tie2_rdata2", 32'(rdata2), 8);

    // Reset in the middle of a write: no ack, no array update.
    @(posedge clk);
    #1;
    req2 = 1'b1; we2 = 1'b1; addr2 = 8'd6; wdata2 = 8'd9;
    @(negedge clk);
    @(negedge clk);
    chk("abort_wbusy_before", 32'(write_busy), 1);
    @(negedge clk);
    #1;
    rst  = 1'b1;
    req2 = 1'b0;
    #1;
    chk_idle_outputs("abort");
    #2;
    rst = 1'b0;
    rd_m[1] = '0; rd_m[2] = '0;
    last_m = 2;
    for (int n = 0; n < 3 * L; n++) begin
      @(negedge clk);
      chk("abort_no_ack2", 32'(ack2), 0);
      chk("abort_wbusy", 32'(write_busy), 0);
    end
    run(1, 0, 8'd6, 8'd0, 0, 0, 8'd0, 8'd0);
    chk("abort_rd6", 32'(rdata1), 6);

    // Single read dropped on ack: the run window covers 3*L cycles.
    run(1, 0, 8'd3, 8'd0, 0, 0, 8'd0, 8'd0);
    chk("drop_rd3", 32'(rdata1), 3);

    // Held request is re-served: acks start L+2 cycles apart (L+1 after the first pulse ends).
    @(posedge clk);
    #1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd3;
    for (int n = 1; n <= 2 * L + 5; n++) begin
      @(negedge clk);
      chk("hold_ack1", 32'(ack1), 32'(n == L + 2 || n == 2 * L + 4));
      chk("hold_ack2", 32'(ack2), 0);
      chk("hold_rdata1", 32'(rdata1), 3);
      if (n == 2 * L + 4) begin
        @(posedge clk);
        #1;
        req1 = 1'b0;
      end
    end

    // Random traffic over a small address window to force collisions.
    for (int k = 0; k < 40; k++) begin
      int unsigned sel;
      sel = $urandom_range(1, 3);
      run(sel[0], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom),
          sel[1], 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning response delay in cycles from request capture to ack; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 8, meaning data width.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have ports req1/req2  input  1  meaning the requester holds the request high until it sees ack.
REQ-007 SHALL have ports we1/we2  input  1  meaning 1=write, 0=read; held stable while req is high.
REQ-008 SHALL have ports addr1/addr2  input  ADDR_W  meaning target address; held stable while req is high.
REQ-009 SHALL have ports wdata1/wdata2  input  DATA_W  meaning write data; held stable while req is high.
REQ-010 SHALL have ports ack1/ack2  output  1  meaning a one-cycle completion pulse per port.
REQ-011 SHALL have ports rdata1/rdata2  output  DATA_W  meaning registered read data, valid with ack and held afterwards.
REQ-012 SHALL have port read_busy  output  1  meaning a read is in flight.
REQ-013 SHALL have port write_busy  output  1  meaning a write is in flight.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP, one transaction at a time.
REQ-015 In IDLE with any req high, SHALL on the next edge capture port/we/addr/wdata, load cnt=LATENCY-1 and enter WAIT.
REQ-016 In WAIT, SHALL go to RESP if cnt==0, else decrement cnt.
REQ-017 In RESP, SHALL for a write update the array and for a read load the granted port's rdata; SHALL assert that port's ack for exactly this cycle; SHALL then return to IDLE.
REQ-018 SHALL make ack high in the cycle following capture edge + LATENCY, i.e. LATENCY cycles after capture.
REQ-019 SHALL arbitrate when req1 and req2 are both high in IDLE by granting the port not served last (last_grant), toggling fairly.
REQ-020 SHALL serve a single requesting port immediately, regardless of last_grant.
REQ-021 SHALL treat a req still high in IDLE after ack as a new transaction; requesters drop req on the edge where they see ack.
REQ-022 SHALL NOT block a request arriving during WAIT/RESP; it is held by the requester and served from IDLE.
REQ-023 SHALL drive read_busy=1 in WAIT/RESP for a captured read, else 0; write_busy likewise for writes; the two are never both 1.
REQ-024 SHALL leave rdata unchanged on write completion and on the other port's completion.
REQ-025 SHALL size the array at 2**ADDR_W x DATA_W, with power-up contents mem[a]=a (truncated to DATA_W); contents are not affected by rst.
REQ-026 SHALL perform a write only in RESP, so an aborted transaction never modifies the array.

Reset
REQ-027 On rst, SHALL immediately set state=IDLE, cnt=0, ack1=ack2=0, rdata1=rdata2=0, read_busy=write_busy=0, and last_grant=port2 (port1 wins the first tie).
REQ-028 On rst during WAIT/RESP, SHALL abort the transaction with no ack and no array write.

Structure
REQ-029 SHALL place state encoding, default LATENCY, ADDR_W and DATA_W in shared package mem_resp_pkg.
REQ-030 SHALL contain one sub-module, mem_array (synchronous write, registered read port, power-up init).

Verification
REQ-031 Reset, then req1 read addr 5 (LATENCY=4) -> ack1 four cycles after capture, rdata1=8'd5, read_busy high during WAIT/RESP, ack2 stays 0.
REQ-032 req1 write addr 5 data 8'd1, then req2 read addr 5 -> ack1 pulse with write_busy high, then rdata2=8'd1 with ack2.
REQ-033 Fresh reset, then req1 write addr 5 data 8'd2 and req2 read addr 5 in the same cycle -> ack1 first, then ack2 with rdata2=8'd2; a following simultaneous pair is served port2 first.
REQ-034 req2 write addr 6 data 8'd9 with rst pulsed mid-WAIT -> no ack2, busy flags clear; a later read addr 6 returns 8'd6.
REQ-035 req1 read addr 3, dropped on ack -> exactly one ack1 within 3*LATENCY cycles; holding req1 high instead -> a second ack1 LATENCY+1 cycles after the first.
